// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the fetch PC, drives the imem req/gnt/rvalid
// handshake and holds one fetched instruction for decode.
//
// state  | meaning
// S_IDLE | no request; wait for a free buffer or a redirect
// S_REQ  | request asserted at req_addr_q, waiting for gnt
// S_WAIT | request granted, waiting for rvalid
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        branch_target_valid_i,
    input  logic [31:0] branch_target_i,
    input  logic        stall_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic        instr_valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_e;

    state_e      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] req_addr_q, req_addr_d;
    logic        drop_q, drop_d;
    logic        valid_q, valid_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_q, pc_d;

    logic        redirect;
    logic [31:0] target;
    logic        buf_free;
    logic        consume;

    assign redirect = branch_target_valid_i;
    assign target   = branch_target_i & 32'hFFFF_FFFC;
    assign buf_free = !valid_q || !stall_i;
    assign consume  = valid_q && !stall_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            fetch_pc_q <= RESET_PC;
            req_addr_q <= RESET_PC;
            drop_q     <= 1'b0;
            valid_q    <= 1'b0;
            instr_q    <= 32'h0;
            pc_q       <= 32'h0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_addr_q <= req_addr_d;
            drop_q     <= drop_d;
            valid_q    <= valid_d;
            instr_q    <= instr_d;
            pc_q       <= pc_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_addr_d = req_addr_q;
        drop_d     = drop_q;
        valid_d    = valid_q && !consume;
        instr_d    = instr_q;
        pc_d       = pc_q;

        if (redirect) begin
            fetch_pc_d = target;
            valid_d    = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (redirect) begin
                    req_addr_d = target;
                    state_d    = S_REQ;
                end else if (buf_free) begin
                    req_addr_d = fetch_pc_q;
                    state_d    = S_REQ;
                end
            end
            S_REQ: begin
                if (redirect) drop_d = 1'b1;
                if (imem_gnt_i) begin
                    // An earlier redirect already parked its target in fetch_pc_q.
                    if (!redirect && !drop_q) fetch_pc_d = req_addr_q + 32'd4;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rvalid_i) begin
                    if (drop_q || redirect) begin
                        drop_d     = 1'b0;
                        req_addr_d = redirect ? target : fetch_pc_q;
                        state_d    = S_REQ;
                    end else begin
                        instr_d = imem_rdata_i;
                        pc_d    = req_addr_q;
                        valid_d = 1'b1;
                        state_d = S_IDLE;
                    end
                end else if (redirect) begin
                    drop_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign imem_req_o    = (state_q == S_REQ);
    assign imem_addr_o   = req_addr_q;
    assign instr_valid_o = valid_q;
    assign instr_o       = instr_q;
    assign pc_o          = pc_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: inputs driven and outputs checked on the
// falling edge, against hand-computed expectations.
module tb_fetch_stage;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        branch_target_valid_i;
    logic [31:0] branch_target_i;
    logic        stall_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        instr_valid_o;
    logic [31:0] instr_o;
    logic [31:0] pc_o;

    int n_cmp = 0;
    int n_err = 0;

    fetch_stage #(.RESET_PC(32'h0000_1000)) dut (
        .clk_i                 (clk_i),
        .rst_ni                (rst_ni),
        .branch_target_valid_i (branch_target_valid_i),
        .branch_target_i       (branch_target_i),
        .stall_i               (stall_i),
        .imem_req_o            (imem_req_o),
        .imem_addr_o           (imem_addr_o),
        .imem_gnt_i            (imem_gnt_i),
        .imem_rvalid_i         (imem_rvalid_i),
        .imem_rdata_i          (imem_rdata_i),
        .instr_valid_o         (instr_valid_o),
        .instr_o               (instr_o),
        .pc_o                  (pc_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic step();
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_ni = 1'b0;
        branch_target_valid_i = 1'b0;
        branch_target_i = 32'h0;
        stall_i = 1'b0;
        imem_gnt_i = 1'b0;
        imem_rvalid_i = 1'b0;
        imem_rdata_i = 32'h0;

        // Reset state
        @(negedge clk_i);
        @(negedge clk_i);
        chk("rst_req",   {31'h0, imem_req_o}, 32'h0);
        chk("rst_valid", {31'h0, instr_valid_o}, 32'h0);
        chk("rst_instr", instr_o, 32'h0);
        chk("rst_pc",    pc_o, 32'h0);
        chk("rst_addr",  imem_addr_o, 32'h0000_1000);
        rst_ni = 1'b1;

        // 1: first fetch, zero-wait memory
        step();
        chk("t1_req",  {31'h0, imem_req_o}, 32'h1);
        chk("t1_addr", imem_addr_o, 32'h0000_1000);
        imem_gnt_i = 1'b1;
        step();
        chk("t1_wait_req", {31'h0, imem_req_o}, 32'h0);
        imem_gnt_i = 1'b0;
        imem_rvalid_i = 1'b1;
        imem_rdata_i = 32'h0050_0093;
        step();
        chk("t1_valid", {31'h0, instr_valid_o}, 32'h1);
        chk("t1_instr", instr_o, 32'h0050_0093);
        chk("t1_pc",    pc_o, 32'h0000_1000);
        imem_rvalid_i = 1'b0;

        // 2: stall holds buffer, no new request
        stall_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t2_req",   {31'h0, imem_req_o}, 32'h0);
            chk("t2_valid", {31'h0, instr_valid_o}, 32'h1);
            chk("t2_instr", instr_o, 32'h0050_0093);
            chk("t2_pc",    pc_o, 32'h0000_1000);
        end
        stall_i = 1'b0;
        step();
        chk("t2_req_after",   {31'h0, imem_req_o}, 32'h1);
        chk("t2_addr_after",  imem_addr_o, 32'h0000_1004);
        chk("t2_valid_after", {31'h0, instr_valid_o}, 32'h0);

        // 3: redirect to 0x2000 while waiting on 0x1004
        imem_gnt_i = 1'b1;
        step();
        imem_gnt_i = 1'b0;
        branch_target_valid_i = 1'b1;
        branch_target_i = 32'h0000_2000;
        step();
        branch_target_valid_i = 1'b0;
        chk("t3_req",   {31'h0, imem_req_o}, 32'h0);
        chk("t3_valid", {31'h0, instr_valid_o}, 32'h0);
        imem_rvalid_i = 1'b1;
        imem_rdata_i = 32'hDEAD_BEEF;
        step();
        imem_rvalid_i = 1'b0;
        chk("t3_dropped", {31'h0, instr_valid_o}, 32'h0);
        chk("t3_req2",    {31'h0, imem_req_o}, 32'h1);
        chk("t3_addr2",   imem_addr_o, 32'h0000_2000);
        imem_gnt_i = 1'b1;
        step();
        imem_gnt_i = 1'b0;
        imem_rvalid_i = 1'b1;
        imem_rdata_i = 32'h1111_1111;
        step();
        imem_rvalid_i = 1'b0;
        chk("t3_valid2", {31'h0, instr_valid_o}, 32'h1);
        chk("t3_instr2", instr_o, 32'h1111_1111);
        chk("t3_pc2",    pc_o, 32'h0000_2000);

        // 4: redirect to 0x3000 during REQ 0x2004, gnt withheld 3 cycles
        step();
        chk("t4_req",  {31'h0, imem_req_o}, 32'h1);
        chk("t4_addr", imem_addr_o, 32'h0000_2004);
        branch_target_valid_i = 1'b1;
        branch_target_i = 32'h0000_3000;
        step();
        branch_target_valid_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk("t4_hold_req",  {31'h0, imem_req_o}, 32'h1);
            chk("t4_hold_addr", imem_addr_o, 32'h0000_2004);
            step();
        end
        chk("t4_hold_addr3", imem_addr_o, 32'h0000_2004);
        imem_gnt_i = 1'b1;
        step();
        imem_gnt_i = 1'b0;
        chk("t4_wait_req", {31'h0, imem_req_o}, 32'h0);
        imem_rvalid_i = 1'b1;
        imem_rdata_i = 32'h0000_0BAD;
        step();
        imem_rvalid_i = 1'b0;
        chk("t4_dropped", {31'h0, instr_valid_o}, 32'h0);
        chk("t4_req2",    {31'h0, imem_req_o}, 32'h1);
        chk("t4_addr2",   imem_addr_o, 32'h0000_3000);

        // 5: redirect to 0x2003 coincident with rvalid
        imem_gnt_i = 1'b1;
        step();
        imem_gnt_i = 1'b0;
        imem_rvalid_i = 1'b1;
        imem_rdata_i = 32'h2222_2222;
        branch_target_valid_i = 1'b1;
        branch_target_i = 32'h0000_2003;
        step();
        imem_rvalid_i = 1'b0;
        branch_target_valid_i = 1'b0;
        chk("t5_valid", {31'h0, instr_valid_o}, 32'h0);
        chk("t5_req",   {31'h0, imem_req_o}, 32'h1);
        chk("t5_addr",  imem_addr_o, 32'h0000_2000);
        imem_gnt_i = 1'b1;
        step();
        imem_gnt_i = 1'b0;
        imem_rvalid_i = 1'b1;
        imem_rdata_i = 32'h3333_3333;
        step();
        imem_rvalid_i = 1'b0;
        chk("t5_pc2", pc_o, 32'h0000_2000);

        // Redirect while stalled clears the buffer; address wraps past 0xFFFFFFFC
        stall_i = 1'b1;
        branch_target_valid_i = 1'b1;
        branch_target_i = 32'hFFFF_FFFF;
        step();
        stall_i = 1'b0;
        branch_target_valid_i = 1'b0;
        chk("wrap_valid", {31'h0, instr_valid_o}, 32'h0);
        chk("wrap_addr",  imem_addr_o, 32'hFFFF_FFFC);
        imem_gnt_i = 1'b1;
        step();
        imem_gnt_i = 1'b0;
        imem_rvalid_i = 1'b1;
        imem_rdata_i = 32'h4444_4444;
        step();
        imem_rvalid_i = 1'b0;
        chk("wrap_pc", pc_o, 32'hFFFF_FFFC);
        step();
        chk("wrap_next", imem_addr_o, 32'h0000_0000);

        // 6: reset in WAIT, stale rvalid after release
        imem_gnt_i = 1'b1;
        step();
        imem_gnt_i = 1'b0;
        chk("t6_held_instr", instr_o, 32'h4444_4444);
        rst_ni = 1'b0;
        #1;
        chk("t6_instr", instr_o, 32'h0);
        chk("t6_pc",    pc_o, 32'h0);
        chk("t6_valid", {31'h0, instr_valid_o}, 32'h0);
        chk("t6_addr",  imem_addr_o, 32'h0000_1000);
        step();
        rst_ni = 1'b1;
        imem_rvalid_i = 1'b1;
        imem_rdata_i = 32'h6666_6666;
        step();
        imem_rvalid_i = 1'b0;
        chk("t6_valid2", {31'h0, instr_valid_o}, 32'h0);
        chk("t6_req",    {31'h0, imem_req_o}, 32'h1);
        chk("t6_addr2",  imem_addr_o, 32'h0000_1000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
